// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the multi-port register file.
//   state_e       - clear sequencer states (ST_CLEAR, ST_READY)
//   REGFILE_WIDTH - default data width
//   REGFILE_DEPTH - default number of registers
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int unsigned REGFILE_WIDTH = 32;
  localparam int unsigned REGFILE_DEPTH = 32;

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: FSM and counter that zero every register entry after reset
// or on a clear request.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   clear    in   restart the clear sequence (sampled on rising edge)
//   busy     out  high while the sequence runs
//   clr_we   out  write-zero strobe into the array
//   clr_addr out  entry being zeroed this cycle
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = REGFILE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  output logic                       busy,
  output logic                       clr_we,
  output logic [$clog2(DEPTH)-1:0]   clr_addr
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      unique case (r_state)
        ST_CLEAR: begin
          // A clear request mid-sequence restarts from entry 0.
          if (clear) begin
            r_cnt <= '0;
          end else if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        ST_READY: begin
          if (clear) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign clr_we   = (r_state == ST_CLEAR);
  assign clr_addr = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with hardwired zero register,
// highest-port-wins write priority, collision flag and hardware clear sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   request a full re-clear
//   busy       out  high while the clear sequencer runs
//   rd_addr    in   read addresses, port i at [i*AW +: AW]
//   rd_data    out  read data, port i at [i*WIDTH +: WIDTH]
//   wr_en      in   per-port write enables
//   wr_addr    in   write addresses
//   wr_data    in   write data
//   wr_collide out  one-cycle pulse after two enabled ports shared an address
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = REGFILE_WIDTH,
  parameter int unsigned DEPTH    = REGFILE_DEPTH,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  output logic                              busy,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]   rd_addr,
  output logic [NUM_RD*WIDTH-1:0]           rd_data,
  input  logic [NUM_WR-1:0]                 wr_en,
  input  logic [NUM_WR*$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]           wr_data,
  output logic                              wr_collide
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic             w_busy;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_addr;
  logic             w_wr_accept;
  logic [NUM_WR-1:0] w_wr_go;
  logic             w_collide;
  logic             r_wr_collide;
  logic [AW-1:0]    w_ra;
  logic [WIDTH-1:0] w_val;

  logic [WIDTH-1:0] r_mem [DEPTH];

  regfile_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // Writes land only in ST_READY and not on the edge that starts a new clear.
  assign w_wr_accept = !w_busy && !clear;

  always_comb begin
    w_wr_go = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      w_wr_go[p] = wr_en[p] && w_wr_accept &&
                   !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0));
    end
  end

  // Collisions are judged on raw enables so address-0 clashes still count.
  always_comb begin
    w_collide = 1'b0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      for (int unsigned j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] && (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])) begin
          w_collide = 1'b1;
        end
      end
    end
    w_collide = w_collide && w_wr_accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_collide <= 1'b0;
    end else begin
      r_wr_collide <= w_collide;
    end
  end

  // Later ports are assigned last, so the highest-indexed port wins a shared address.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (w_wr_go[p]) begin
          r_mem[wr_addr[p*AW +: AW]] <= wr_data[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    w_ra    = '0;
    w_val   = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      w_ra  = rd_addr[r*AW +: AW];
      w_val = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (w_wr_go[p] && (wr_addr[p*AW +: AW] == w_ra)) begin
          w_val = wr_data[p*WIDTH +: WIDTH];
        end
      end
`endif
      // Busy and zero-register rules override both array and forwarded data.
      if (w_busy || ((ZERO_REG != 0) && (w_ra == '0))) begin
        w_val = '0;
      end
      rd_data[r*WIDTH +: WIDTH] = w_val;
    end
  end

  assign busy       = w_busy;
  assign wr_collide = r_wr_collide;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed self-checking bench for regfile_mp with a
// behavioural model (array + remaining-clear-edges counter).
module tb_regfile_mp;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned NUM_WR = 2;
  localparam int unsigned AW     = 5;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     clear;
  logic                     busy;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*WIDTH-1:0]  rd_data;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*WIDTH-1:0]  wr_data;
  logic                     wr_collide;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .busy       (busy),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_collide (wr_collide)
  );

  // Behavioural model: m_left counts clear edges still owed (0 means ready).
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_left;
  bit               m_collide;

  initial begin
    m_left    = DEPTH;
    m_collide = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left    = DEPTH;
        m_collide = 1'b0;
      end else if (m_left > 0) begin
        m_collide = 1'b0;
        if (clear) begin
          m_left = DEPTH;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end
      end else if (clear) begin
        m_left    = DEPTH;
        m_collide = 1'b0;
      end else begin
        m_collide = wr_en[0] && wr_en[1] && (wr_addr[0 +: AW] == wr_addr[AW +: AW]);
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && wr_addr[p*AW +: AW] != 0) m_mem[wr_addr[p*AW +: AW]] = wr_data[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] ra);
    logic [WIDTH-1:0] v;
    if (m_left > 0 || ra == 0) return '0;
    v = m_mem[ra];
`ifdef REGFILE_BYPASS_EN
    if (!clear) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] == ra) v = wr_data[p*WIDTH +: WIDTH];
      end
    end
`endif
    return v;
  endfunction

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", {31'd0, busy}, {31'd0, m_left > 0});
      check("wr_collide", {31'd0, wr_collide}, {31'd0, m_collide});
      for (int r = 0; r < NUM_RD; r++) begin
        check("rd_data", rd_data[r*WIDTH +: WIDTH], exp_rd(rd_addr[r*AW +: AW]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0;
    wr_en = '0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_en   = 2'b01;
    wr_addr[0 +: AW] = a;
    wr_data[0 +: WIDTH] = d;
  endtask

  task automatic expect_clear_run(input string nm);
    check(nm, {31'd0, busy}, 32'd1);
    repeat (DEPTH - 1) begin
      tick();
      check(nm, {31'd0, busy}, 32'd1);
    end
    tick();
    check(nm, {31'd0, busy}, 32'd0);
  endtask

  task automatic expect_all_zero(input string nm);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr[0 +: AW]  = AW'(i);
      rd_addr[AW +: AW] = AW'(DEPTH - 1 - i);
      #1;
      check(nm, rd_data[0 +: WIDTH], 32'd0);
      check(nm, rd_data[WIDTH +: WIDTH], 32'd0);
      tick();
    end
  endtask

  initial begin
    int k;
    idle();
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset release: writes during the clear are lost.
    check("busy_after_reset", {31'd0, busy}, 32'd1);
    for (int c = 0; c < DEPTH - 1; c++) begin
      wr0(5'd3, 32'h1111_0000 | c);
      tick();
    end
    check("busy_edge31", {31'd0, busy}, 32'd1);
    idle();
    tick();
    check("busy_edge32", {31'd0, busy}, 32'd0);
    expect_all_zero("reset_zero");

    // Two ports to r5: port 1 wins, collision pulses once.
    wr_en = 2'b11;
    wr_addr = {5'd5, 5'd5};
    wr_data = {32'h5555_0002, 32'hAAAA_0001};
    tick();
    idle();
    rd_addr[0 +: AW] = 5'd5;
    #1;
    check("r5_priority", rd_data[0 +: WIDTH], 32'h5555_0002);
    check("collide_pulse", {31'd0, wr_collide}, 32'd1);
    tick();
    check("collide_drop", {31'd0, wr_collide}, 32'd0);

    // Zero register ignores writes.
    wr0(5'd0, 32'hDEAD_BEEF);
    tick();
    idle();
    rd_addr[0 +: AW] = 5'd0;
    #1;
    check("r0_zero", rd_data[0 +: WIDTH], 32'd0);

    // Same-cycle read of a written address.
    wr0(5'd7, 32'hCAFE_0007);
    tick();
    wr0(5'd7, 32'h1234_5678);
    rd_addr[0 +: AW] = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r7_same_cycle", rd_data[0 +: WIDTH], 32'h1234_5678);
`else
    check("r7_same_cycle", rd_data[0 +: WIDTH], 32'hCAFE_0007);
`endif
    tick();
    idle();
    #1;
    check("r7_next_cycle", rd_data[0 +: WIDTH], 32'h1234_5678);

    // Random traffic; narrow addresses half the time to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      clear = ($urandom_range(0, 299) == 0);
      wr_en = NUM_WR'($urandom_range(0, 3));
      for (int p = 0; p < NUM_WR; p++) begin
        wr_addr[p*AW +: AW]    = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        wr_data[p*WIDTH +: WIDTH] = $urandom;
      end
      for (int r = 0; r < NUM_RD; r++) begin
        rd_addr[r*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      end
      tick();
    end
    idle();

    k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    check("ready_timeout", {31'd0, busy}, 32'd0);

    // Fill with ones, then clear request.
    for (int i = 0; i < DEPTH; i++) begin
      wr0(AW'(i), 32'hFFFF_FFFF);
      tick();
    end
    idle();
    rd_addr[0 +: AW] = 5'd9;
    #1;
    check("fill_r9", rd_data[0 +: WIDTH], 32'hFFFF_FFFF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expect_clear_run("clear_busy");
    expect_all_zero("clear_zero");

    // Reset at cnt=10 mid-clear restarts the full sequence.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #2;
    check("busy_in_reset", {31'd0, busy}, 32'd1);
    tick();
    rst_n = 1'b1;
    expect_clear_run("rerun_busy");
    expect_all_zero("rerun_zero");

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
